// File: rtl/mul_seq_16b.sv
// Iterative unsigned 16x16->32 multiplier: one shared 16-bit CLA, 16 shift-add steps.

// 16-bit carry-lookahead adder: four 4-bit groups with group-level lookahead.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] p;
  logic [15:0] g;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  cg;
  logic        carry;

  // Bit propagate/generate, group lookahead, then in-group carries from each group carry-in.
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    gp    = '0;
    gg    = '0;
    cg    = '0;
    sum   = '0;
    carry = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    cg[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
    for (int k = 0; k < 4; k++) begin
      carry = cg[k];
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ carry;
        carry      = g[4*k+j] | (p[4*k+j] & carry);
      end
    end
    c_out = cg[4];
  end

endmodule

module mul_seq_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int unsigned W    = 16;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    mcand_q;
  logic [W-1:0]    acc_hi_q;
  logic [W-1:0]    acc_lo_q;
  logic [CNTW-1:0] cnt_q;
  logic [2*W-1:0]  prod_q;
  logic            busy_q;
  logic            done_q;

  logic [W-1:0]    addend;
  logic [W-1:0]    sum;
  logic            c_out;
  logic [2*W-1:0]  shift_d;

  // Partial product is the multiplicand when the current multiplier LSB is set.
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  cla_16b u_cla (
    .a     (acc_hi_q),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // 33-bit {c_out, sum, acc_lo} shifted right by one; carry lands in acc_hi[15].
  assign shift_d = {c_out, sum, acc_lo_q[W-1:1]};

  // Control FSM and datapath registers; busy/done are flopped alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            acc_lo_q <= b;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
        end
        S_RUN: begin
          acc_hi_q <= shift_d[2*W-1:W];
          acc_lo_q <= shift_d[W-1:0];
          cnt_q    <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(W - 1)) begin
            prod_q  <= shift_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mul_seq_16b.sv
// Self-checking bench for mul_seq_16b: directed cases plus randomized regression against a
// cycle-level behavioural model (countdown + plain a*b).
module tb_mul_seq_16b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  mul_seq_16b dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  int          acc_cyc = 0;
  int          done_cnt = 0;

  // reference model state
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_pend = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model the next edge from the driven inputs, advance one clock, compare at negedge.
  task automatic cycle();
    if (rst) begin
      m_run  = 1'b0;
      m_left = 0;
      m_done = 1'b0;
      m_prod = '0;
    end else if (m_run) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_run  = 1'b0;
        m_prod = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_run   = 1'b1;
        m_left  = 16;
        m_pend  = 32'(a) * 32'(b);
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("product", product, m_prod);
    if (done === 1'b1) begin
      done_cnt++;
      chk("latency", 32'(cyc - acc_cyc), 32'd17);
    end
  endtask

  // Run until done, optionally pulsing start with junk operands mid-run (must be ignored).
  task automatic wait_done(input bit noise);
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      start = noise && ($urandom_range(0, 7) == 0);
      a     = 16'($urandom);
      b     = 16'($urandom);
      cycle();
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    cycle();
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  initial begin
    int gap;
    int busy_cycles;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // reset then idle
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("idle_product", product, 32'h0);

    // basic multiply; count busy cycles directly
    launch(16'h0003, 16'h0005);
    busy_cycles = 1;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      cycle();
      if (busy === 1'b1) busy_cycles++;
    end
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_len", 32'(busy_cycles), 32'd16);
    chk("basic", product, 32'h0000000F);
    for (int i = 0; i < 3; i++) cycle();
    chk("basic_hold", product, 32'h0000000F);

    // carry-out path
    launch(16'hFFFF, 16'hFFFF);
    wait_done(1'b0);
    chk("ffff_sq", product, 32'hFFFE0001);
    cycle();
    launch(16'h8000, 16'h0002);
    wait_done(1'b0);
    chk("8000x2", product, 32'h00010000);
    cycle();

    // start ignored while busy
    launch(16'd7, 16'd9);
    for (int i = 0; i < 5; i++) cycle();
    a = 16'd1;
    b = 16'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(1'b0);
    chk("ignore_mid", product, 32'h0000003F);

    // back-to-back from the DONE cycle
    launch(16'd2, 16'd3);
    chk("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) cycle();
    chk("b2b_hold", product, 32'h0000003F);
    wait_done(1'b0);
    chk("b2b", product, 32'h00000006);
    cycle();

    // reset mid-operation
    launch(16'h1234, 16'h5678);
    for (int i = 0; i < 7; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    launch(16'h1234, 16'h5678);
    wait_done(1'b0);
    chk("after_rst", product, 32'h06260060);
    cycle();

    // random regression with random gaps and ignored mid-run starts
    for (int n = 0; n < 1000; n++) begin
      launch(16'($urandom), 16'($urandom));
      wait_done(1'b1);
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++) cycle();
    end
    for (int i = 0; i < 3; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq_16b.md
# mul_seq_16b

Iterative unsigned 16x16→32 multiplier controller that sequences a single instance of the team's 16-bit carry-lookahead adder (cla_16b) through 16 shift-add steps. It sits beside the ALU as a multi-cycle execution unit. It takes operands through a start/done handshake and holds the last product until the next operation completes. Using one shared 16-bit adder instead of an array multiplier keeps area low; the cost is a fixed latency.

## Interface
Parameters:
- none (width fixed at 16; counter width fixed at 4)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  16  multiplicand, unsigned; latched on accepted start
- b  input  16  multiplier, unsigned; latched on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse, high while state is DONE
- product  output  32  registered result {hi, lo}; holds value between operations

## Operation
Internal registers:
- mcand[15:0]
- acc_hi[15:0]
- acc_lo[15:0], which initially holds the multiplier
- cnt[3:0]
- state ∈ {IDLE, RUN, DONE}
- prod_q[31:0]

Adder:
- One cla_16b instance: a = acc_hi, b = acc_lo[0] ? mcand : 16'h0000, c_in = 0; outputs sum and c_out.
- No other adder in the block; cnt is incremented with a plain 4-bit increment.

States:
- IDLE: start=1 → latch mcand=a, acc_lo=b, acc_hi=0, cnt=0; go to RUN. start=0 → stay.
- RUN, each edge:
  - {acc_hi, acc_lo} ← {c_out, sum, acc_lo[15:1]}, a 33-bit right shift of {c_out, sum, acc_lo}.
  - cnt ← cnt+1.
  - When cnt==15 on this edge: go to DONE and load prod_q ← the post-shift {acc_hi, acc_lo} value.
- DONE:
  - start=1 → latch new operands as in IDLE, go to RUN (back-to-back).
  - Otherwise go to IDLE.

Arithmetic:
- Full unsigned product; no overflow possible in 32 bits.
- c_out of each step is captured as acc_hi[15] after the shift, so no carry is lost.

Start and outputs:
- start while in RUN is ignored: no latch, no queueing, no effect on the current operation.
- a and b may change freely after the accepted-start edge.
- prod_q is written only on the RUN→DONE edge. The previous product stays visible throughout a subsequent RUN.

Reset:
- Applies at any state, including mid-RUN.
- state=IDLE, cnt=0, mcand=acc_hi=acc_lo=0, prod_q=0.
- An in-flight operation is discarded; no done pulse follows.
- rst has priority over start on the same edge.

## Timing
- Reset values: busy=0, done=0, product=32'h0.
- Accepted-start edge E0: busy=1 from the cycle after E0.
- Iteration edges: E1..E16 perform the 16 shift-add iterations.
- Edge E16: state → DONE, prod_q updated; busy=0 and done=1 in the cycle after E16.
- Latency: done asserts 17 cycles after the start-accept edge.
- Throughput with start held high: one product per 17 cycles.
- done width: exactly 1 cycle.
- busy and done are never high together.
- The adder path (acc_hi → CLA → acc_hi) is the only multi-level combinational path and must close in one cycle.
- Outputs are decoded from registered state only; no combinational path from inputs to outputs.

## Test plan
- Reset then idle:
  - rst=1 for 2 cycles, then start=0 for 5 cycles → busy=0, done=0, product=0 throughout.
- Basic multiply:
  - a=16'h0003, b=16'h0005, start pulse → busy high for exactly 16 cycles, done pulse 17 cycles after accept, product=32'h0000000F, held after done until the next completion.
- Carry-out path:
  - a=16'hFFFF, b=16'hFFFF → product=32'hFFFE0001.
  - a=16'h8000, b=16'h0002 → product=32'h00010000.
- Start ignored while busy and back-to-back:
  - Start with a=7, b=9; pulse start mid-RUN with a=1, b=1 → result 32'h0000003F, no extra operation.
  - Assert start with a=2, b=3 in the DONE cycle → busy the next cycle, second done 17 cycles later with product=32'h00000006.
  - product stays 32'h3F during the second RUN.
- Reset mid-operation:
  - Assert rst at iteration 8 of a=16'h1234, b=16'h5678 → next cycle busy=0, done=0, product=0.
  - No done pulse in the following 20 cycles.
  - A fresh start then yields 32'h06260060.
- Random regression:
  - 1,000 random a,b with random start gaps → each product equals a*b (32-bit).
  - Every done is exactly 17 cycles after its accept.
